collision_manager: RTL and testbench
====================================

# collision_manager

Sequential, parametrised collision unit between the ghost/pac-man movers and the score/lives controller. Once per game step it checks pac-man against all N ghosts. A hit is either a shared tile or a tile swap, where pac-man and a ghost passed through each other during the step. Lethal hits are resolved with priority over ghost eats. Simultaneous ghost eats are serialised into one score event per cycle using the 200/400/800/1600 eat chain.

## Interface
Parameters:
- N_GHOST, 4, number of ghosts (1..8)
- COORD_W, 6, tile coordinate width
- SCORE_BASE, 200, score for the first ghost of a fright period

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  game-step strobe; positions and states valid this cycle
- i_pacman_x, i_pacman_y  in  COORD_W each  pac-man tile
- i_ghost_x, i_ghost_y  in  N_GHOST*COORD_W each  ghost g at bits [g*COORD_W +: COORD_W]
- i_ghost_state  in  N_GHOST*4  ghost g at [g*4 +: 4]; shared G_* encoding
- i_fright_start  in  1  power-pellet pulse; restarts eat chain
- i_clear  in  1  new life/level; returns block to start condition
- o_pacman_eaten  out  1  one-cycle pulse on lethal hit
- o_dead  out  1  sticky lethal flag, cleared only by i_clear/i_rst
- o_ghost_eaten  out  N_GHOST  one-hot pulse, ghost being awarded this cycle
- o_score_valid  out  1  pulse; o_score_add valid
- o_score_add  out  16  points for the ghost eaten this cycle, else 0

## Operation
- Hit_g on tick = (pac cur == ghost_g cur), OR (prev_valid AND pac cur == ghost_g prev AND ghost_g cur == pac prev).
- Previous positions (pac + all ghosts) are registered on every accepted tick. prev_valid is set after the first accepted tick.
- Hit classification: G_CHASE/G_SCATTER → lethal; G_FRIGHTENED → edible; G_IDLE, G_DIE and other encodings → ignored.
- States: IDLE, AWARD, DEAD.
- IDLE + tick:
  - Any lethal hit → pulse o_pacman_eaten, set o_dead, go DEAD. Edible hits in the same tick are discarded.
  - Else any edible hit → load pending mask, go AWARD.
  - Else stay IDLE.
- AWARD: each cycle, award the lowest-index pending ghost.
  - o_ghost_eaten[g]=1, o_score_valid=1, o_score_add = SCORE_BASE << chain.
  - Clear that pending bit; chain = min(chain+1, 3).
  - Return to IDLE in the same cycle the last bit is awarded.
- i_tick in AWARD or DEAD is ignored: no evaluation, no prev update.
- i_fright_start sets chain=0 immediately, in any state.
  - If it coincides with the tick, the awards from that tick start at SCORE_BASE.
  - During AWARD, the next award uses SCORE_BASE.
- i_clear (priority over tick and fright_start):
  - Next state IDLE; pending=0, chain=0, prev_valid=0, o_dead=0.
  - Any award in flight is dropped.
- Score arithmetic: 16-bit. SCORE_BASE<<3 must fit in 16 bits; chain saturates, so the 5th and later eats give SCORE_BASE*8.

## Timing
- Reset values: all outputs 0; state IDLE; chain 0; pending 0; prev_valid 0; prev positions 0.
- Tick at cycle t:
  - o_pacman_eaten and o_dead rise at t+1.
  - k-th award (k=1..N_GHOST) at t+k, consecutive cycles.
  - State is IDLE again at t+K+1 when K ghosts are pending.
- Upstream spaces ticks ≥ N_GHOST+1 cycles apart; closer ticks are dropped as above.
- All outputs are registered; no combinational input-to-output path.
- i_clear at t: outputs 0 from t+1. An award scheduled for t+1 does not appear.
- Asynchronous reset mid-AWARD: outputs 0 immediately; no further awards.

## Test plan
- Same tile, lethal: pac (5,5), ghost1 (5,5) G_CHASE, tick → o_pacman_eaten pulse at t+1; o_dead stays 1; later ticks produce nothing until i_clear.
- Swap crossing: tick A with pac (3,4), ghost0 (4,4) G_SCATTER; tick B with pac (4,4), ghost0 (3,4) → lethal at B+1. The same positions on the first tick after i_clear give no hit.
- Double eat: fright_start, then ghosts 0 and 2 on pac tile, both G_FRIGHTENED → t+1: eaten=0001, score 200; t+2: eaten=0100, score 400.
- Chain saturation: five successive single eats without a new fright_start → scores 200, 400, 800, 1600, 1600. A fright_start then gives 200 on the next eat.
- Priority/ignore: ghost0 G_FRIGHTENED and ghost1 G_CHASE both on pac tile → only o_pacman_eaten, no score. Ghost in G_DIE on pac tile → no outputs.
- i_clear one cycle after a tick with 3 edible hits → only the first award (200) appears; no later pulses; o_dead=0; chain 0.

Source files
------------

// File: rtl/collision_manager.sv
// Per-step pac-man vs. ghost collision detection; lethal hits win over eats,
// and simultaneous eats are serialised into one score event per cycle.
module collision_manager #(
    parameter int N_GHOST    = 4,
    parameter int COORD_W    = 6,
    parameter int SCORE_BASE = 200
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_tick,
    input  logic [COORD_W-1:0]           i_pacman_x,
    input  logic [COORD_W-1:0]           i_pacman_y,
    input  logic [N_GHOST*COORD_W-1:0]   i_ghost_x,
    input  logic [N_GHOST*COORD_W-1:0]   i_ghost_y,
    input  logic [N_GHOST*4-1:0]         i_ghost_state,
    input  logic                         i_fright_start,
    input  logic                         i_clear,
    output logic                         o_pacman_eaten,
    output logic                         o_dead,
    output logic [N_GHOST-1:0]           o_ghost_eaten,
    output logic                         o_score_valid,
    output logic [15:0]                  o_score_add
);

    // state    | meaning
    // ST_IDLE  | waiting for a tick to evaluate
    // ST_AWARD | serialising pending ghost eats, one per cycle
    // ST_DEAD  | lethal hit seen; ticks ignored until i_clear
    typedef enum logic [1:0] {ST_IDLE, ST_AWARD, ST_DEAD} state_t;

    localparam logic [3:0]  G_CHASE      = 4'd1;
    localparam logic [3:0]  G_SCATTER    = 4'd2;
    localparam logic [3:0]  G_FRIGHTENED = 4'd3;
    localparam logic [15:0] SCORE_BASE_C = 16'(SCORE_BASE);

    state_t                       state_q, state_d;
    logic [N_GHOST-1:0]           pending_q, pending_d;
    logic [1:0]                   chain_q, chain_d;
    logic                         prev_valid_q, prev_valid_d;
    logic [COORD_W-1:0]           prev_pac_x_q, prev_pac_x_d;
    logic [COORD_W-1:0]           prev_pac_y_q, prev_pac_y_d;
    logic [N_GHOST*COORD_W-1:0]   prev_gx_q, prev_gx_d;
    logic [N_GHOST*COORD_W-1:0]   prev_gy_q, prev_gy_d;
    logic                         eaten_q, eaten_d;
    logic                         dead_q, dead_d;
    logic [N_GHOST-1:0]           ghost_eaten_q, ghost_eaten_d;
    logic                         score_valid_q, score_valid_d;
    logic [15:0]                  score_add_q, score_add_d;

    logic [N_GHOST-1:0]           hit, lethal, edible;
    logic [N_GHOST-1:0]           award_src, grant;
    logic [1:0]                   chain_eff;

    always_comb begin
        hit    = '0;
        lethal = '0;
        edible = '0;
        for (int g = 0; g < N_GHOST; g++) begin
            hit[g] = ((i_pacman_x == i_ghost_x[g*COORD_W +: COORD_W]) &&
                      (i_pacman_y == i_ghost_y[g*COORD_W +: COORD_W])) ||
                     (prev_valid_q &&
                      (i_pacman_x == prev_gx_q[g*COORD_W +: COORD_W]) &&
                      (i_pacman_y == prev_gy_q[g*COORD_W +: COORD_W]) &&
                      (i_ghost_x[g*COORD_W +: COORD_W] == prev_pac_x_q) &&
                      (i_ghost_y[g*COORD_W +: COORD_W] == prev_pac_y_q));
            lethal[g] = hit[g] && ((i_ghost_state[g*4 +: 4] == G_CHASE) ||
                                   (i_ghost_state[g*4 +: 4] == G_SCATTER));
            edible[g] = hit[g] && (i_ghost_state[g*4 +: 4] == G_FRIGHTENED);
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        prev_valid_d  = prev_valid_q;
        prev_pac_x_d  = prev_pac_x_q;
        prev_pac_y_d  = prev_pac_y_q;
        prev_gx_d     = prev_gx_q;
        prev_gy_d     = prev_gy_q;
        eaten_d       = 1'b0;
        dead_d        = dead_q;
        ghost_eaten_d = '0;
        score_valid_d = 1'b0;
        score_add_d   = '0;
        award_src     = '0;
        grant         = '0;
        chain_eff     = i_fright_start ? 2'd0 : chain_q;
        chain_d       = chain_eff;

        if (i_clear) begin
            state_d      = ST_IDLE;
            pending_d    = '0;
            chain_d      = 2'd0;
            prev_valid_d = 1'b0;
            dead_d       = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_tick) begin
                        prev_valid_d = 1'b1;
                        prev_pac_x_d = i_pacman_x;
                        prev_pac_y_d = i_pacman_y;
                        prev_gx_d    = i_ghost_x;
                        prev_gy_d    = i_ghost_y;
                        if (|lethal) begin
                            eaten_d = 1'b1;
                            dead_d  = 1'b1;
                            state_d = ST_DEAD;
                        end else if (|edible) begin
                            award_src = edible;
                            state_d   = ST_AWARD;
                        end
                    end
                end
                ST_AWARD: begin
                    // The first award of a tick is issued at the tick edge itself,
                    // so this state lingers one cycle after pending empties.
                    if (|pending_q) award_src = pending_q;
                    else            state_d   = ST_IDLE;
                end
                ST_DEAD: ;
                default: state_d = ST_IDLE;
            endcase

            if (|award_src) begin
                grant         = award_src & (~award_src + N_GHOST'(1));
                pending_d     = award_src & ~grant;
                ghost_eaten_d = grant;
                score_valid_d = 1'b1;
                score_add_d   = SCORE_BASE_C << chain_eff;
                chain_d       = (chain_eff == 2'd3) ? 2'd3 : chain_eff + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            chain_q       <= 2'd0;
            prev_valid_q  <= 1'b0;
            prev_pac_x_q  <= '0;
            prev_pac_y_q  <= '0;
            prev_gx_q     <= '0;
            prev_gy_q     <= '0;
            eaten_q       <= 1'b0;
            dead_q        <= 1'b0;
            ghost_eaten_q <= '0;
            score_valid_q <= 1'b0;
            score_add_q   <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            chain_q       <= chain_d;
            prev_valid_q  <= prev_valid_d;
            prev_pac_x_q  <= prev_pac_x_d;
            prev_pac_y_q  <= prev_pac_y_d;
            prev_gx_q     <= prev_gx_d;
            prev_gy_q     <= prev_gy_d;
            eaten_q       <= eaten_d;
            dead_q        <= dead_d;
            ghost_eaten_q <= ghost_eaten_d;
            score_valid_q <= score_valid_d;
            score_add_q   <= score_add_d;
        end
    end

    assign o_pacman_eaten = eaten_q;
    assign o_dead         = dead_q;
    assign o_ghost_eaten  = ghost_eaten_q;
    assign o_score_valid  = score_valid_q;
    assign o_score_add    = score_add_q;

endmodule

// File: tb/tb_collision_manager.sv
// Directed bench for collision_manager: hit detection, priority, eat chain,
// clear and asynchronous reset behaviour.
module tb_collision_manager;

    localparam int N = 4;
    localparam int W = 6;
    localparam logic [3:0] G_IDLE       = 4'd0;
    localparam logic [3:0] G_CHASE      = 4'd1;
    localparam logic [3:0] G_SCATTER    = 4'd2;
    localparam logic [3:0] G_FRIGHTENED = 4'd3;
    localparam logic [3:0] G_DIE        = 4'd4;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick;
    logic [W-1:0]   pac_x, pac_y;
    logic [N*W-1:0] gx, gy;
    logic [N*4-1:0] gst;
    logic           fright;
    logic           clear;
    logic           pacman_eaten, dead, score_valid;
    logic [N-1:0]   ghost_eaten;
    logic [15:0]    score_add;

    int ntests = 0;
    int nfail  = 0;

    collision_manager #(.N_GHOST(N), .COORD_W(W), .SCORE_BASE(200)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_tick         (tick),
        .i_pacman_x     (pac_x),
        .i_pacman_y     (pac_y),
        .i_ghost_x      (gx),
        .i_ghost_y      (gy),
        .i_ghost_state  (gst),
        .i_fright_start (fright),
        .i_clear        (clear),
        .o_pacman_eaten (pacman_eaten),
        .o_dead         (dead),
        .o_ghost_eaten  (ghost_eaten),
        .o_score_valid  (score_valid),
        .o_score_add    (score_add)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ghost(input int g, input int x, input int y, input logic [3:0] st);
        gx[g*W +: W]  = W'(x);
        gy[g*W +: W]  = W'(y);
        gst[g*4 +: 4] = st;
    endtask

    task automatic park_ghosts();
        for (int g = 0; g < N; g++) set_ghost(g, 50 + g, 50, G_IDLE);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        clk1();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; fright = 1'b0; clear = 1'b0;
        pac_x = '0; pac_y = '0; gx = '0; gy = '0; gst = '0;
        park_ghosts();
        #12;
        chk("rst_eaten", 32'(pacman_eaten), 0);
        chk("rst_dead", 32'(dead), 0);
        chk("rst_ghost_eaten", 32'(ghost_eaten), 0);
        chk("rst_score_valid", 32'(score_valid), 0);
        chk("rst_score_add", 32'(score_add), 0);
        clk1();
        rst = 1'b0;
        clk1();

        // same tile, lethal
        pac_x = 5; pac_y = 5;
        set_ghost(1, 5, 5, G_CHASE);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("lethal_eaten_pulse", 32'(pacman_eaten), 1);
        chk("lethal_dead", 32'(dead), 1);
        clk1();
        chk("lethal_eaten_drop", 32'(pacman_eaten), 0);
        chk("lethal_dead_sticky", 32'(dead), 1);
        tick = 1'b1; clk1(); tick = 1'b0;
        clk1();
        chk("dead_tick_no_eaten", 32'(pacman_eaten), 0);
        chk("dead_tick_no_score", 32'(score_valid), 0);
        do_clear();
        chk("clear_dead", 32'(dead), 0);
        park_ghosts();

        // swap crossing
        pac_x = 3; pac_y = 4;
        set_ghost(0, 4, 4, G_SCATTER);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("swapA_no_hit", 32'(pacman_eaten), 0);
        repeat (5) clk1();
        pac_x = 4; pac_y = 4;
        set_ghost(0, 3, 4, G_SCATTER);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("swapB_lethal", 32'(pacman_eaten), 1);
        do_clear();
        // crossing back would match the stored previous tiles, but they are stale
        pac_x = 3; pac_y = 4;
        set_ghost(0, 4, 4, G_SCATTER);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("swap_after_clear", 32'(pacman_eaten), 0);
        chk("swap_after_clear_dead", 32'(dead), 0);
        do_clear();
        park_ghosts();

        // double eat
        fright = 1'b1; clk1(); fright = 1'b0;
        pac_x = 10; pac_y = 10;
        set_ghost(0, 10, 10, G_FRIGHTENED);
        set_ghost(2, 10, 10, G_FRIGHTENED);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("dbl_mask1", 32'(ghost_eaten), 32'b0001);
        chk("dbl_score1", 32'(score_add), 200);
        chk("dbl_valid1", 32'(score_valid), 1);
        clk1();
        chk("dbl_mask2", 32'(ghost_eaten), 32'b0100);
        chk("dbl_score2", 32'(score_add), 400);
        clk1();
        chk("dbl_done_valid", 32'(score_valid), 0);
        chk("dbl_done_add", 32'(score_add), 0);
        clk1();
        park_ghosts();

        // chain saturation
        fright = 1'b1; clk1(); fright = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] exp_score;
            exp_score = (i == 0) ? 16'd200 : (i == 1) ? 16'd400 :
                        (i == 2) ? 16'd800 : 16'd1600;
            pac_x = W'(20 + i); pac_y = 20;
            set_ghost(3, 20 + i, 20, G_FRIGHTENED);
            tick = 1'b1; clk1(); tick = 1'b0;
            chk("chain_mask", 32'(ghost_eaten), 32'b1000);
            chk("chain_score", 32'(score_add), 32'(exp_score));
            repeat (4) clk1();
        end
        fright = 1'b1; clk1(); fright = 1'b0;
        pac_x = 30; pac_y = 20;
        set_ghost(3, 30, 20, G_FRIGHTENED);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("chain_restart", 32'(score_add), 200);
        repeat (4) clk1();
        park_ghosts();

        // lethal beats edible, G_DIE ignored
        pac_x = 32; pac_y = 32;
        set_ghost(0, 32, 32, G_FRIGHTENED);
        set_ghost(1, 32, 32, G_CHASE);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("prio_eaten", 32'(pacman_eaten), 1);
        chk("prio_no_score", 32'(score_valid), 0);
        chk("prio_no_ghost", 32'(ghost_eaten), 0);
        clk1();
        chk("prio_no_score_later", 32'(score_valid), 0);
        do_clear();
        park_ghosts();
        pac_x = 34; pac_y = 34;
        set_ghost(2, 34, 34, G_DIE);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("die_eaten", 32'(pacman_eaten), 0);
        chk("die_score", 32'(score_valid), 0);
        clk1();
        chk("die_score_later", 32'(score_valid), 0);
        park_ghosts();
        repeat (4) clk1();

        // clear one cycle after a triple eat
        fright = 1'b1; clk1(); fright = 1'b0;
        pac_x = 40; pac_y = 40;
        set_ghost(0, 40, 40, G_FRIGHTENED);
        set_ghost(1, 40, 40, G_FRIGHTENED);
        set_ghost(3, 40, 40, G_FRIGHTENED);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("clr_first_mask", 32'(ghost_eaten), 32'b0001);
        chk("clr_first_score", 32'(score_add), 200);
        do_clear();
        chk("clr_drop_valid", 32'(score_valid), 0);
        chk("clr_drop_mask", 32'(ghost_eaten), 0);
        chk("clr_dead", 32'(dead), 0);
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("clr_no_late_award", 32'(score_valid), 0);
        end
        park_ghosts();
        pac_x = 42; pac_y = 42;
        set_ghost(1, 42, 42, G_FRIGHTENED);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("clr_chain_zero", 32'(score_add), 200);
        chk("clr_chain_mask", 32'(ghost_eaten), 32'b0010);
        repeat (4) clk1();
        park_ghosts();

        // asynchronous reset in the middle of an award run
        pac_x = 44; pac_y = 44;
        set_ghost(0, 44, 44, G_FRIGHTENED);
        set_ghost(2, 44, 44, G_FRIGHTENED);
        set_ghost(3, 44, 44, G_FRIGHTENED);
        tick = 1'b1; clk1(); tick = 1'b0;
        chk("arst_first_award", 32'(score_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_now", 32'(score_valid), 0);
        chk("arst_mask_now", 32'(ghost_eaten), 0);
        clk1();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("arst_no_award", 32'(score_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
